// File: rtl/sdram_req_splitter.sv
// Splits a user transfer into burst-aligned SDRAM commands, queues them for the
// controller and reports completion once every issued read has returned.
package sdram_pkg;
   localparam int unsigned ADDR_WIDTH = 24;
   localparam logic WRITE_CMD = 1'b1;
   localparam logic READ_CMD  = 1'b0;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic                  rw;
      logic                  auto_precharge_en;
   } sdram_cmd_t;
endpackage

module sdram_req_splitter #(
   parameter int unsigned ADDR_WIDTH = 24,
   parameter int unsigned BURST_LEN  = 8,
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [LEN_WIDTH-1:0]   req_len,
   input  logic                   req_rw,
   output logic                   cmd_fifo_valid,
   input  logic                   cmd_fifo_ready,
   output sdram_pkg::sdram_cmd_t  cmd_fifo_data,
   input  logic                   resp_valid,
   input  logic                   resp_ready,
   input  logic                   resp_last,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BURST_LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BURST_LEN);
   localparam logic [PTR_W:0]        FULL_CNT   = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GEN,
      S_WAIT
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
   logic                    rw_q, rw_d;
   logic                    done_q, done_d;
   sdram_pkg::sdram_cmd_t   mem_q [FIFO_DEPTH];
   sdram_pkg::sdram_cmd_t   mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]          count_q, count_d;
   logic [LEN_WIDTH:0]      rd_pending_q, rd_pending_d;

   sdram_pkg::sdram_cmd_t   push_cmd;
   logic                    push, pop, rd_inc, rd_dec;

   assign req_ready      = (state_q == S_IDLE);
   assign busy           = (state_q != S_IDLE);
   assign cmd_fifo_valid = (count_q != '0);
   assign cmd_fifo_data  = mem_q[rd_ptr_q];
   assign done           = done_q;

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      remaining_d  = remaining_q;
      rw_d         = rw_q;
      done_d       = 1'b0;
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      rd_pending_d = rd_pending_q;
      push         = 1'b0;
      pop          = cmd_fifo_valid & cmd_fifo_ready;

      push_cmd                   = '0;
      push_cmd.addr              = base_q;
      push_cmd.rw                = rw_q;
      push_cmd.auto_precharge_en = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               base_d      = req_addr & ALIGN_MASK;
               remaining_d = req_len;
               rw_d        = req_rw;
               state_d     = (req_len != '0) ? S_GEN : S_WAIT;
            end
         end
         S_GEN: begin
            // Fullness is judged before this cycle's pop, so a full queue always stalls.
            if (count_q != FULL_CNT) begin
               push        = 1'b1;
               base_d      = base_q + ADDR_STEP;
               remaining_d = remaining_q - LEN_WIDTH'(1);
               if (remaining_q == LEN_WIDTH'(1)) state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (count_q == '0 && rd_pending_q == '0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = push_cmd;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase

      rd_inc = pop & (mem_q[rd_ptr_q].rw == sdram_pkg::READ_CMD);
      rd_dec = resp_valid & resp_ready & resp_last;
      if (rd_inc && !rd_dec)
         rd_pending_d = rd_pending_q + (LEN_WIDTH+1)'(1);
      else if (!rd_inc && rd_dec && rd_pending_q != '0)
         rd_pending_d = rd_pending_q - (LEN_WIDTH+1)'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         base_q       <= '0;
         remaining_q  <= '0;
         rw_q         <= 1'b0;
         done_q       <= 1'b0;
         mem_q        <= '{default: '0};
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         rd_pending_q <= '0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         remaining_q  <= remaining_d;
         rw_q         <= rw_d;
         done_q       <= done_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         rd_pending_q <= rd_pending_d;
      end
   end

endmodule

// File: tb/tb_sdram_req_splitter.sv
// Bench for sdram_req_splitter: directed scenarios plus random traffic against a
// transfer-level model (expected command list, outstanding-read count, done rule).
module tb_sdram_req_splitter;
   import sdram_pkg::*;

   localparam int unsigned AW = 24;
   localparam int unsigned BL = 8;
   localparam int unsigned LW = 16;
   localparam int unsigned FD = 4;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            req_valid, req_ready, req_rw;
   logic [AW-1:0]   req_addr;
   logic [LW-1:0]   req_len;
   logic            cmd_fifo_valid, cmd_fifo_ready;
   sdram_cmd_t      cmd_fifo_data;
   logic            resp_valid, resp_ready, resp_last;
   logic            busy, done;

   always #5 clk = ~clk;

   sdram_req_splitter #(
      .ADDR_WIDTH(AW),
      .BURST_LEN (BL),
      .LEN_WIDTH (LW),
      .FIFO_DEPTH(FD)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_len       (req_len),
      .req_rw        (req_rw),
      .cmd_fifo_valid(cmd_fifo_valid),
      .cmd_fifo_ready(cmd_fifo_ready),
      .cmd_fifo_data (cmd_fifo_data),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_last     (resp_last),
      .busy          (busy),
      .done          (done)
   );

   int checks = 0;
   int errors = 0;

   // Model: idle flag, done expected this cycle, commands issued but not yet popped,
   // and reads popped but not yet answered.
   bit         m_idle = 1'b1;
   bit         m_done = 1'b0;
   sdram_cmd_t m_q[$];
   int         m_pend = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("req_ready", 64'(req_ready), 64'(m_idle));
      chk("busy", 64'(busy), 64'(!m_idle));
      chk("done", 64'(done), 64'(m_done));
      if (m_q.size() == 0)
         chk("valid_when_empty", 64'(cmd_fifo_valid), 64'd0);
      else if (cmd_fifo_valid)
         chk("cmd_data", 64'(cmd_fifo_data), 64'(m_q[0]));
   endtask

   task automatic model_step();
      bit         pop, inc, dec, nxt_idle, nxt_done;
      logic [AW-1:0] a;
      sdram_cmd_t c;
      pop = cmd_fifo_valid && cmd_fifo_ready && (m_q.size() != 0);
      inc = pop && (m_q[0].rw == READ_CMD);
      dec = resp_valid && resp_ready && resp_last;
      nxt_idle = m_idle;
      nxt_done = 1'b0;
      if (!m_idle && m_q.size() == 0 && m_pend == 0) begin
         nxt_done = 1'b1;
         nxt_idle = 1'b1;
      end
      if (pop) void'(m_q.pop_front());
      if (inc && !dec) m_pend++;
      else if (!inc && dec && m_pend > 0) m_pend--;
      if (m_idle && req_valid) begin
         nxt_idle = 1'b0;
         a = req_addr & ~AW'(BL - 1);
         for (int i = 0; i < int'(req_len); i++) begin
            c.addr = a;
            c.rw = req_rw;
            c.auto_precharge_en = 1'b1;
            m_q.push_back(c);
            a = a + AW'(BL);
         end
      end
      m_idle = nxt_idle;
      m_done = nxt_done;
   endtask

   task automatic tick();
      check_outputs();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #1;
      chk("rst_valid", 64'(cmd_fifo_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd1);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_data", 64'(cmd_fifo_data), 64'd0);
      m_idle = 1'b1;
      m_done = 1'b0;
      m_q.delete();
      m_pend = 0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic request(input logic [AW-1:0] a, input logic [LW-1:0] n, input logic rw);
      req_addr  = a;
      req_len   = n;
      req_rw    = rw;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
   endtask

   task automatic drain(input string tag, input int max_cyc);
      int n;
      n = 0;
      cmd_fifo_ready = 1'b1;
      req_valid = 1'b0;
      while (!(m_idle && !m_done && m_q.size() == 0) && n < max_cyc) begin
         resp_valid = (m_pend > 0);
         resp_ready = (m_pend > 0);
         resp_last  = (m_pend > 0);
         tick();
         n++;
      end
      resp_valid = 1'b0;
      resp_ready = 1'b0;
      resp_last  = 1'b0;
      chk({tag, "_timeout"}, 64'(n < max_cyc), 64'd1);
      tick();
   endtask

   initial begin
      req_valid = 1'b0; req_addr = '0; req_len = '0; req_rw = 1'b0;
      cmd_fifo_ready = 1'b0; resp_valid = 1'b0; resp_ready = 1'b0; resp_last = 1'b0;

      @(negedge clk);
      do_reset();
      tick();

      // Unaligned write, ready held high.
      cmd_fifo_ready = 1'b1;
      request(24'h000105, 16'd3, WRITE_CMD);
      chk("t1_valid_t1", 64'(cmd_fifo_valid), 64'd0);
      tick();
      chk("t1_valid_t2", 64'(cmd_fifo_valid), 64'd1);
      chk("t1_addr0", 64'(cmd_fifo_data.addr), 64'h000100);
      chk("t1_rw", 64'(cmd_fifo_data.rw), 64'd1);
      chk("t1_ap", 64'(cmd_fifo_data.auto_precharge_en), 64'd1);
      tick();
      chk("t1_addr1", 64'(cmd_fifo_data.addr), 64'h000108);
      tick();
      chk("t1_addr2", 64'(cmd_fifo_data.addr), 64'h000110);
      tick();
      chk("t1_done_early", 64'(done), 64'd0);
      tick();
      chk("t1_done", 64'(done), 64'd1);
      tick();
      chk("t1_done_once", 64'(done), 64'd0);
      tick();

      // Backpressure with a full queue.
      cmd_fifo_ready = 1'b0;
      request(24'h001000, 16'd10, WRITE_CMD);
      for (int i = 0; i < 8; i++) tick();
      chk("t2_count_sat", 64'(dut.count_q), 64'd4);
      chk("t2_valid", 64'(cmd_fifo_valid), 64'd1);
      chk("t2_head", 64'(cmd_fifo_data.addr), 64'h001000);
      drain("t2", 60);

      // Read completion tracking.
      cmd_fifo_ready = 1'b1;
      request(24'h002000, 16'd2, READ_CMD);
      tick();
      tick();
      chk("t3_pop2_valid", 64'(cmd_fifo_valid), 64'd1);
      resp_valid = 1'b1; resp_ready = 1'b1; resp_last = 1'b1;
      tick();
      resp_valid = 1'b0; resp_ready = 1'b0; resp_last = 1'b0;
      chk("t3_pending", 64'(dut.rd_pending_q), 64'd1);
      for (int i = 0; i < 5; i++) tick();
      chk("t3_no_done", 64'(done), 64'd0);
      resp_valid = 1'b1; resp_ready = 1'b1; resp_last = 1'b1;
      tick();
      resp_valid = 1'b0; resp_ready = 1'b0; resp_last = 1'b0;
      chk("t3_done_r1", 64'(done), 64'd0);
      tick();
      chk("t3_done_r2", 64'(done), 64'd1);
      tick();

      // Address wrap-around.
      request(24'hFFFFF8, 16'd2, WRITE_CMD);
      tick();
      chk("t4_addr0", 64'(cmd_fifo_data.addr), 64'hFFFFF8);
      tick();
      chk("t4_addr1", 64'(cmd_fifo_data.addr), 64'h000000);
      drain("t4", 20);

      // Zero-length transfer.
      request(24'h000040, 16'd0, READ_CMD);
      chk("t5_valid_t1", 64'(cmd_fifo_valid), 64'd0);
      tick();
      chk("t5_done_t2", 64'(done), 64'd1);
      chk("t5_valid_t2", 64'(cmd_fifo_valid), 64'd0);
      tick();
      chk("t5_ready_t3", 64'(req_ready), 64'd1);
      tick();

      // Reset with commands queued.
      cmd_fifo_ready = 1'b0;
      request(24'h003000, 16'd3, WRITE_CMD);
      for (int i = 0; i < 5; i++) tick();
      chk("t6_queued", 64'(dut.count_q), 64'd3);
      do_reset();
      tick();
      cmd_fifo_ready = 1'b1;
      request(24'h004008, 16'd1, WRITE_CMD);
      drain("t6", 20);
      for (int i = 0; i < 3; i++) tick();

      // Random traffic.
      for (int i = 0; i < 2000; i++) begin
         req_valid      = ($urandom % 8) == 0;
         req_addr       = AW'($urandom);
         req_len        = LW'($urandom % 7);
         req_rw         = 1'($urandom % 2);
         cmd_fifo_ready = ($urandom % 10) < 7;
         resp_valid     = ($urandom % 3) == 0;
         resp_ready     = ($urandom % 4) != 0;
         resp_last      = 1'($urandom % 2);
         tick();
      end
      drain("rand", 300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
